// File: rtl/sm_mac_accumulator.sv
// Sequential sign-magnitude accumulator: sums a frame of terms into one wider result.
// Optional build macro SM_ACC_SAT_EN: clamp magnitude on overflow instead of wrapping.
//
// state  | meaning
// ACCUM  | accepting terms, in_ready=1
// DONE   | holding frame result, out_valid=1 until out_ready
module sm_mac_accumulator #(
  parameter int DATA_W  = 16,
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 18
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              in_data,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACC_W-1:0]               out_data,
  output logic                           out_ovf,
  output logic [$clog2(N_TERMS+1)-1:0]   out_count
);

  localparam int MW = ACC_W - 1;
  localparam int CW = $clog2(N_TERMS + 1);

  localparam logic [0:0] S_ACCUM = 1'b0;
  localparam logic [0:0] S_DONE  = 1'b1;

  logic [0:0]    state;
  logic          acc_sign;
  logic [MW-1:0] acc_mag;
  logic [CW-1:0] count;
  logic          ovf;

  logic [MW-1:0] t_mag;
  logic          t_sign;
  logic [MW:0]   sum_ext;
  logic [MW-1:0] nxt_mag;
  logic          nxt_sign;
  logic          add_ovf;
  logic [CW-1:0] count_inc;
  logic          accept;
  logic          frame_end;

  assign in_ready  = (state == S_ACCUM);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;

  // A -0 term is folded to +0 here so the add below never sees a negative zero.
  assign t_mag     = MW'(in_data[DATA_W-2:0]);
  assign t_sign    = in_data[DATA_W-1] && (t_mag != '0);
  assign sum_ext   = {1'b0, acc_mag} + {1'b0, t_mag};
  assign count_inc = count + CW'(1);
  assign frame_end = in_last || (count_inc == CW'(N_TERMS));

  always_comb begin
    nxt_mag  = acc_mag;
    nxt_sign = acc_sign;
    add_ovf  = 1'b0;
    if (t_sign == acc_sign) begin
      nxt_mag = sum_ext[MW-1:0];
      add_ovf = sum_ext[MW];
`ifdef SM_ACC_SAT_EN
      if (sum_ext[MW]) nxt_mag = '1;
`endif
    end else if (t_mag > acc_mag) begin
      nxt_mag  = t_mag - acc_mag;
      nxt_sign = t_sign;
    end else begin
      nxt_mag  = acc_mag - t_mag;
    end
    if (nxt_mag == '0) nxt_sign = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_ACCUM;
      acc_sign  <= 1'b0;
      acc_mag   <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_count <= '0;
    end else if (clear) begin
      state    <= S_ACCUM;
      acc_sign <= 1'b0;
      acc_mag  <= '0;
      count    <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        S_ACCUM: begin
          if (accept) begin
            if (frame_end) begin
              state     <= S_DONE;
              out_data  <= {nxt_sign, nxt_mag};
              out_ovf   <= ovf | add_ovf;
              out_count <= count_inc;
              acc_sign  <= 1'b0;
              acc_mag   <= '0;
              count     <= '0;
              ovf       <= 1'b0;
            end else begin
              acc_sign <= nxt_sign;
              acc_mag  <= nxt_mag;
              count    <= count_inc;
              ovf      <= ovf | add_ovf;
            end
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_ACCUM;
        end
        default: state <= S_ACCUM;
      endcase
    end
  end

endmodule
